// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared definitions for the bit-serial adder controller.
//   sa_state_t   : controller state encoding (IDLE, RUN, DONE)
//   SA_MAX_WIDTH : largest operand width the controller accepts
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_t;

    localparam int SA_MAX_WIDTH = 64;

endpackage

// File: rtl/full_adder_cell.sv
// full_adder_cell
//   One-bit full adder built from two half adders and an OR, purely
//   combinational.
//   a_i, b_i : addend bits
//   c_i      : carry in
//   s_o      : a_i ^ b_i ^ c_i
//   c_o      : majority(a_i, b_i, c_i)
module full_adder_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (
        .a_i (a_i),
        .b_i (b_i),
        .s_o (s0),
        .c_o (c0)
    );

    half_adder u_ha1 (
        .a_i (s0),
        .b_i (c_i),
        .s_o (s_o),
        .c_o (c1)
    );

    // The two half-adder carries can never both be 1, so OR gives the majority.
    assign c_o = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// half_adder
//   One-bit half adder, purely combinational.
//   a_i, b_i : addend bits
//   s_o      : a_i ^ b_i
//   c_o      : a_i & b_i
module half_adder (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   Bit-serial WIDTH-bit adder. Operands are latched on an accepted start,
//   then one bit pair per clock is pushed through a single full-adder cell,
//   LSB first, with the carry fed back through a flop. The result is
//   published on sum/cout together with a one-cycle done pulse.
//   clk    : clock, all state changes on the rising edge
//   rst_n  : synchronous active-low reset
//   start  : request, honoured only in IDLE
//   a, b   : operands, sampled with start
//   cin    : carry in, sampled with start
//   busy   : high while an addition is in RUN or DONE
//   done   : one-cycle pulse, sum/cout just updated
//   sum    : registered result, held until the next completion
//   cout   : registered carry out, held with sum
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    generate
        if (WIDTH < 2 || WIDTH > SA_MAX_WIDTH) begin : g_bad_width
            $error("serial_adder_ctrl: WIDTH out of range");
        end
    endgenerate

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    sa_state_t        state_q;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic [WIDTH-1:0] sp_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             s_d;
    logic             co_d;
    logic [WIDTH-1:0] sp_d;

    full_adder_cell u_cell (
        .a_i (sa_q[0]),
        .b_i (sb_q[0]),
        .c_i (carry_q),
        .s_o (s_d),
        .c_o (co_d)
    );

    // Sum bits enter at the MSB, so after WIDTH shifts bit 0 sits at the LSB.
    assign sp_d = {s_d, sp_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sp_q    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        sa_q    <= a;
                        sb_q    <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sa_q    <= sa_q >> 1;
                    sb_q    <= sb_q >> 1;
                    sp_q    <= sp_d;
                    carry_q <= co_d;
                    cnt_q   <= cnt_q + CNT_ONE;
                    // Counter value WIDTH-1 means this edge handles the MSB.
                    if (cnt_q == CNT_LAST) begin
                        sum_q   <= sp_d;
                        cout_q  <= co_d;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl
//   Directed and sampled-sweep bench for serial_adder_ctrl at WIDTH=8.
//   A transaction-level model predicts busy/done/sum/cout every cycle; the
//   directed tests additionally pin hand-computed results and timing.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         cin   = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int total  = 0;
    int bad    = 0;
    int n_done = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: m_t counts cycles since acceptance (0 = idle). An operation
    // occupies W+1 busy cycles and its result appears in the last of them.
    int           m_t    = 0;
    logic [W:0]   m_res  = '0;
    logic [W-1:0] m_sum  = '0;
    logic         m_cout = 1'b0;
    bit           m_on   = 1'b0;

    always @(posedge clk) begin
        m_on <= 1'b1;
        if (!rst_n) begin
            m_t    <= 0;
            m_sum  <= '0;
            m_cout <= 1'b0;
        end else if (m_t == 0) begin
            if (start) begin
                m_t   <= 1;
                m_res <= {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            end
        end else if (m_t == W + 1) begin
            m_t <= 0;
        end else begin
            m_t <= m_t + 1;
            if (m_t == W) {m_cout, m_sum} <= m_res;
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("model busy", busy, m_t != 0);
            chk("model done", done, m_t == W + 1);
            chk("model sum", sum, m_sum);
            chk("model cout", cout, m_cout);
            if (done) n_done++;
        end
    end

    // Waits (bounded) for done; lat counts edges from the accepting edge,
    // which itself counts as 1.
    task automatic wait_done(input string tag, output int lat, output int busy_cycles);
        bit found = 0;
        lat = 1;
        busy_cycles = 0;
        while (!found && lat <= 40) begin
            if (busy) busy_cycles++;
            if (done) found = 1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        chk({tag, " done seen"}, found, 1'b1);
    endtask

    task automatic run_add(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                           input logic [W-1:0] es, input logic ec, input string tag,
                           output int lat, output int busy_cycles);
        @(negedge clk);
        a = ta; b = tb_; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = ~ta; b = ~tb_; cin = ~tc;
        wait_done(tag, lat, busy_cycles);
        chk({tag, " sum"}, sum, es);
        chk({tag, " cout"}, cout, ec);
        $display("add %s: a=0x%02h b=0x%02h cin=%0d -> sum=0x%02h cout=%0d", tag, ta, tb_, tc, sum, cout);
        @(negedge clk);
        if (busy) busy_cycles++;
    endtask

    initial begin
        int lat;
        int bc;
        int d0;
        bit found;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic [W:0]   rs;

        repeat (3) @(negedge clk);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset sum", sum, 8'h00);
        chk("reset cout", cout, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic add with latency and busy-length checks.
        run_add(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "basic", lat, bc);
        chk("basic latency", lat, 9);
        chk("basic busy cycles", bc, 9);

        // Second operation: previous result must be held until its done.
        @(negedge clk);
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (done) found = 1;
            else begin
                chk("hold sum", sum, 8'h96);
                @(negedge clk);
            end
        end
        chk("hold done seen", found, 1'b1);
        chk("hold new sum", sum, 8'h30);
        $display("add hold: a=0x10 b=0x20 cin=0 -> sum=0x%02h cout=%0d", sum, cout);

        run_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ovf1", lat, bc);
        run_add(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "ovf2", lat, bc);

        // start held high through RUN and DONE with other operands.
        @(negedge clk);
        a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 8'h40; b = 8'h01;
        d0 = n_done;
        repeat (9) @(negedge clk);
        chk("ignored start one done", n_done - d0, 1);
        chk("ignored start first result", sum, 8'h33);
        @(negedge clk);
        start = 1'b0;
        wait_done("ignored start second", lat, bc);
        chk("ignored start second sum", sum, 8'h41);
        $display("add ignored-start: first=0x33 second sum=0x%02h", sum);

        // Reset at the 4th RUN edge.
        @(negedge clk);
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset busy", busy, 1'b0);
        chk("midreset done", done, 1'b0);
        chk("midreset sum", sum, 8'h00);
        chk("midreset cout", cout, 1'b0);
        rst_n = 1'b1;
        d0 = n_done;
        repeat (12) @(negedge clk);
        chk("midreset no done", n_done - d0, 0);
        $display("reset mid-run: busy=%0d sum=0x%02h", busy, sum);
        run_add(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, "after reset", lat, bc);

        // Sampled sweep with corner operands first.
        for (int i = 0; i < 1200; i++) begin
            case (i)
                0:       begin ra = 8'h00; rb = 8'h00; end
                1:       begin ra = 8'hFF; rb = 8'h00; end
                2:       begin ra = 8'h80; rb = 8'h80; end
                3:       begin ra = 8'hAA; rb = 8'h55; end
                default: begin ra = W'($urandom); rb = W'($urandom); end
            endcase
            rc = 1'($urandom_range(0, 1));
            rs = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            run_add(ra, rb, rc, rs[W-1:0], rs[W], "sweep", lat, bc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
